// File: rtl/vx_gbar_sched.sv
// -----------------------------------------------------------------------------
// vx_gbar_sched
// Cluster-level global-barrier scheduler. NUM_REQS socket requesters share
// one barrier-count table. A round-robin arbiter accepts at most one arrival
// per cycle. When the last participant of a barrier arrives, a one-cycle
// release pulse is broadcast in the following cycle.
//
// Optional feature macro: VX_GBAR_SCHED_ERR_EN
//   When defined, the err/err_id ports exist. They flag the first arrival
//   whose participant count disagrees with the size latched for a barrier
//   that is already in progress. err is sticky until reset.
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous reset, active-low
//   req_valid    in   [NUM_REQS]        arrival request per requester
//   req_id       in   [NUM_REQS*BID_W]  barrier id, slice i = requester i
//   req_size_m1  in   [NUM_REQS*SZ_W]   participants-1, slice i = requester i
//   req_ready    out  [NUM_REQS]        one-hot grant (combinational)
//   rsp_valid    out  release pulse, one cycle, no backpressure
//   rsp_id       out  [BID_W]           released barrier id
//   busy         out  any arrival counter nonzero or release pending
//   err          out  sticky size-mismatch flag   (VX_GBAR_SCHED_ERR_EN)
//   err_id       out  [BID_W] id of first mismatch (VX_GBAR_SCHED_ERR_EN)
// -----------------------------------------------------------------------------
module vx_gbar_sched #(
    parameter int NUM_REQS     = 4,
    parameter int NUM_BARRIERS = 16,
    parameter int MAX_SIZE     = 64,
    // Derived widths; keep at their defaults.
    parameter int BID_W        = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    parameter int SZ_W         = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*BID_W-1:0] req_id,
    input  logic [NUM_REQS*SZ_W-1:0]  req_size_m1,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      rsp_valid,
    output logic [BID_W-1:0]          rsp_id,
`ifdef VX_GBAR_SCHED_ERR_EN
    output logic                      err,
    output logic [BID_W-1:0]          err_id,
`endif
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    // Counter is one bit wider than the size field so MAX_SIZE arrivals never wrap.
    localparam logic [SZ_W:0] CNT_ZERO = {(SZ_W+1){1'b0}};
    localparam logic [SZ_W:0] CNT_ONE  = {{SZ_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_REL_IMM  = 3'd1,   // single-participant barrier, release at once
        ACT_START    = 3'd2,   // first arrival of a multi-participant barrier
        ACT_INC      = 3'd3,   // intermediate arrival
        ACT_REL_LAST = 3'd4    // final arrival, release and clear
    } act_e;

    // Barrier table state
    logic [SZ_W:0]           cnt_r   [NUM_BARRIERS];
    logic [SZ_W-1:0]         size_r  [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] valid_r;
    logic [PTR_W-1:0]        rr_ptr_r;
    logic                    rsp_valid_r;
    logic [BID_W-1:0]        rsp_id_r;

    // Arbitration / decode
    logic [NUM_REQS-1:0]     ready_s;
    logic                    found_s;
    logic [PTR_W-1:0]        gidx_s;
    logic [PTR_W-1:0]        ptr_nxt_s;
    logic                    xfer_s;
    logic [BID_W-1:0]        sel_id_s;
    logic [SZ_W-1:0]         sel_size_s;
    logic                    id_ok_s;
    logic [SZ_W:0]           cur_cnt_s;
    logic [SZ_W-1:0]         cur_size_s;
    logic                    cur_valid_s;
    act_e                    act_s;
    logic                    any_cnt_s;

    // Round-robin grant: first valid requester at or after the pointer, wrapping.
    always_comb begin
        ready_s = {NUM_REQS{1'b0}};
        found_s = 1'b0;
        gidx_s  = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQS; k++) begin
            int idx;
            idx = (int'(rr_ptr_r) + k) % NUM_REQS;
            if (!found_s && req_valid[idx]) begin
                found_s = 1'b1;
                gidx_s  = PTR_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            ready_s[gidx_s] = 1'b1;
        end else begin
            ready_s = {NUM_REQS{1'b0}};
        end
    end

    assign req_ready = ready_s;
    assign xfer_s    = found_s;

    // Pointer advances to the slot after the granted requester.
    always_comb begin
        if (int'(gidx_s) == NUM_REQS - 1) begin
            ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            ptr_nxt_s = gidx_s + 1'b1;
        end
    end

    assign sel_id_s   = req_id[gidx_s*BID_W +: BID_W];
    assign sel_size_s = req_size_m1[gidx_s*SZ_W +: SZ_W];
    // Ids beyond the table are accepted but have no effect.
    assign id_ok_s    = (int'(sel_id_s) < NUM_BARRIERS);

    // Classify the accepted arrival against the selected barrier's state.
    always_comb begin
        act_s       = ACT_NONE;
        cur_cnt_s   = CNT_ZERO;
        cur_size_s  = {SZ_W{1'b0}};
        cur_valid_s = 1'b0;
        if (xfer_s && id_ok_s) begin
            cur_cnt_s   = cnt_r[sel_id_s];
            cur_size_s  = size_r[sel_id_s];
            cur_valid_s = valid_r[sel_id_s];
            if (!cur_valid_s) begin
                if (sel_size_s == {SZ_W{1'b0}}) begin
                    act_s = ACT_REL_IMM;
                end else begin
                    act_s = ACT_START;
                end
            end else if (cur_cnt_s == {1'b0, cur_size_s}) begin
                act_s = ACT_REL_LAST;
            end else begin
                act_s = ACT_INC;
            end
        end else begin
            act_s = ACT_NONE;
        end
    end

    // Barrier table, arbitration pointer and release pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                cnt_r[b]  <= CNT_ZERO;
                size_r[b] <= {SZ_W{1'b0}};
            end
            valid_r     <= {NUM_BARRIERS{1'b0}};
            rr_ptr_r    <= {PTR_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {BID_W{1'b0}};
        end else begin
            rsp_valid_r <= 1'b0;
            if (xfer_s) begin
                rr_ptr_r <= ptr_nxt_s;
            end
            case (act_s)
                ACT_NONE: begin
                end
                ACT_REL_IMM: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= sel_id_s;
                end
                ACT_START: begin
                    size_r[sel_id_s]  <= sel_size_s;
                    valid_r[sel_id_s] <= 1'b1;
                    cnt_r[sel_id_s]   <= CNT_ONE;
                end
                ACT_INC: begin
                    cnt_r[sel_id_s] <= cur_cnt_s + CNT_ONE;
                end
                ACT_REL_LAST: begin
                    cnt_r[sel_id_s]   <= CNT_ZERO;
                    valid_r[sel_id_s] <= 1'b0;
                    rsp_valid_r       <= 1'b1;
                    rsp_id_r          <= sel_id_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;

    // Any in-progress barrier; derived purely from counter flops.
    always_comb begin
        any_cnt_s = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (cnt_r[b] != CNT_ZERO) begin
                any_cnt_s = 1'b1;
            end else begin
                any_cnt_s = any_cnt_s;
            end
        end
    end

    assign busy = any_cnt_s | rsp_valid_r;

`ifdef VX_GBAR_SCHED_ERR_EN
    logic             err_r;
    logic [BID_W-1:0] err_id_r;
    logic             mismatch_s;

    // A later arrival disagreeing with the latched size; counting still uses the latched size.
    assign mismatch_s = xfer_s && id_ok_s && cur_valid_s && (sel_size_s != cur_size_s);

    // Sticky error flag capturing only the first offending barrier id.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r    <= 1'b0;
            err_id_r <= {BID_W{1'b0}};
        end else if (mismatch_s && !err_r) begin
            err_r    <= 1'b1;
            err_id_r <= sel_id_s;
        end
    end

    assign err    = err_r;
    assign err_id = err_id_r;
`endif

endmodule

// File: tb/tb_vx_gbar_sched.sv
// -----------------------------------------------------------------------------
// tb_vx_gbar_sched
// Directed self-checking bench for vx_gbar_sched with default parameters
// (4 requesters, 16 barriers, 64 max participants). Inputs change 1 ns after
// the rising edge; registered outputs are sampled there, the combinational
// grant is sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vx_gbar_sched;

    localparam int NR    = 4;
    localparam int BID_W = 4;
    localparam int SZ_W  = 6;

    logic                   clk;
    logic                   reset;
    logic [NR-1:0]          req_valid;
    logic [NR*BID_W-1:0]    req_id;
    logic [NR*SZ_W-1:0]     req_size_m1;
    logic [NR-1:0]          req_ready;
    logic                   rsp_valid;
    logic [BID_W-1:0]       rsp_id;
    logic                   busy;
`ifdef VX_GBAR_SCHED_ERR_EN
    logic                   err;
    logic [BID_W-1:0]       err_id;
`endif

    int errors = 0;
    int checks = 0;

    vx_gbar_sched dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_size_m1 (req_size_m1),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
`ifdef VX_GBAR_SCHED_ERR_EN
        .err         (err),
        .err_id      (err_id),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus: one arrival from requester r, leaves us at posedge+1.
    task automatic arrive(input int r, input logic [BID_W-1:0] id, input logic [SZ_W-1:0] sz);
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_id[r*BID_W +: BID_W] = id;
        req_size_m1[r*SZ_W +: SZ_W] = sz;
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = '0;
        req_id = '0;
        req_size_m1 = '0;
        #22;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 4'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
`ifdef VX_GBAR_SCHED_ERR_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        for (int a = 0; a < 2; a++) begin
            arrive(0, 4'd3, 6'd2);
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++;
                $display("FAIL basic_partial%0d got rsp=%b busy=%b exp rsp=0 busy=1", a, rsp_valid, busy); end
        end
        arrive(0, 4'd3, 6'd2);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd3) begin errors++;
            $display("FAIL basic_release got rsp=%b id=%0d exp rsp=1 id=3", rsp_valid, rsp_id); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL basic_after got rsp=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_immediate();
        arrive(2, 4'd5, 6'd0);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd5 || busy !== 1'b1) begin errors++;
            $display("FAIL imm_release got rsp=%b id=%0d busy=%b exp 1 5 1", rsp_valid, rsp_id, busy); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL imm_after got rsp=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_rr_order();
        logic [NR-1:0] exp_g;
        do_reset();
        for (int r = 0; r < NR; r++) begin
            req_id[r*BID_W +: BID_W] = 4'd1;
            req_size_m1[r*SZ_W +: SZ_W] = 6'd3;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            @(negedge clk);
            exp_g = 4'b0001 << k;
            checks++; if (req_ready !== exp_g) begin errors++;
                $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, exp_g); end
            @(posedge clk); #1;
            req_valid[k] = 1'b0;
            checks++; if (rsp_valid !== (k == NR-1) || (k == NR-1 && rsp_id !== 4'd1)) begin errors++;
                $display("FAIL rr_rsp%0d got rsp=%b id=%0d exp rsp=%0d id=1", k, rsp_valid, rsp_id, (k == NR-1)); end
        end
    endtask

    task automatic test_rr_wrap();
        arrive(1, 4'd9, 6'd0);   // pointer now 2
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd9) begin errors++;
            $display("FAIL wrap_first got rsp=%b id=%0d exp 1 9", rsp_valid, rsp_id); end
        req_id[0 +: BID_W] = 4'd9;      req_size_m1[0 +: SZ_W] = 6'd0;
        req_id[BID_W +: BID_W] = 4'd9;  req_size_m1[SZ_W +: SZ_W] = 6'd0;
        req_valid = 4'b0011;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++;
            $display("FAIL wrap_grant got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++;
            $display("FAIL wrap_grant2 got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd9) begin errors++;
            $display("FAIL wrap_b2b got rsp=%b id=%0d exp 1 9", rsp_valid, rsp_id); end
    endtask

    task automatic test_back_to_back();
        logic [BID_W-1:0] ids [4];
        ids[0] = 4'd2; ids[1] = 4'd7; ids[2] = 4'd2; ids[3] = 4'd7;
        req_valid = 4'b0001;
        for (int a = 0; a < 4; a++) begin
            req_id[0 +: BID_W] = ids[a];
            req_size_m1[0 +: SZ_W] = 6'd1;
            @(posedge clk); #1;
            checks++; if (rsp_valid !== (a >= 2) || (a >= 2 && rsp_id !== ids[a])) begin errors++;
                $display("FAIL b2b_arr%0d got rsp=%b id=%0d exp rsp=%0d id=%0d", a, rsp_valid, rsp_id, (a >= 2), ids[a]); end
        end
        req_valid = '0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL b2b_after got rsp=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_fresh_gen();
        arrive(3, 4'd3, 6'd1);
        arrive(3, 4'd3, 6'd1);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd3) begin errors++;
            $display("FAIL fresh_rel1 got rsp=%b id=%0d exp 1 3", rsp_valid, rsp_id); end
        arrive(3, 4'd3, 6'd1);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL fresh_start got rsp=%b busy=%b exp 0 1", rsp_valid, busy); end
        arrive(3, 4'd3, 6'd1);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd3) begin errors++;
            $display("FAIL fresh_rel2 got rsp=%b id=%0d exp 1 3", rsp_valid, rsp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        arrive(0, 4'd4, 6'd3);
        arrive(1, 4'd4, 6'd3);
        arrive(2, 4'd11, 6'd0);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd11 || busy !== 1'b1) begin errors++;
            $display("FAIL mid_pre got rsp=%b id=%0d busy=%b exp 1 11 1", rsp_valid, rsp_id, busy); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 4'd0 || busy !== 1'b0) begin errors++;
            $display("FAIL mid_async got rsp=%b id=%0d busy=%b exp 0 0 0", rsp_valid, rsp_id, busy); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) begin
            arrive(a, 4'd4, 6'd3);
            checks++; if (rsp_valid !== (a == 3) || (a == 3 && rsp_id !== 4'd4)) begin errors++;
                $display("FAIL mid_arr%0d got rsp=%b id=%0d exp rsp=%0d id=4", a, rsp_valid, rsp_id, (a == 3)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max_size();
        int early;
        early = 0;
        for (int a = 0; a < 63; a++) begin
            arrive(1, 4'd15, 6'd63);
            if (rsp_valid !== 1'b0) early++;
        end
        checks++; if (early !== 0 || busy !== 1'b1) begin errors++;
            $display("FAIL max_early got early=%0d busy=%b exp 0 1", early, busy); end
        arrive(1, 4'd15, 6'd63);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd15) begin errors++;
            $display("FAIL max_release got rsp=%b id=%0d exp 1 15", rsp_valid, rsp_id); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL max_after got busy=%b exp 0", busy); end
    endtask

    task automatic test_size_mismatch();
        arrive(0, 4'd6, 6'd3);
`ifdef VX_GBAR_SCHED_ERR_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early got=%b exp=0", err); end
`endif
        arrive(1, 4'd6, 6'd1);
`ifdef VX_GBAR_SCHED_ERR_EN
        checks++; if (err !== 1'b1 || err_id !== 4'd6) begin errors++;
            $display("FAIL err_set got err=%b id=%0d exp 1 6", err, err_id); end
`endif
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mism_2 got rsp=%b exp 0", rsp_valid); end
        arrive(2, 4'd6, 6'd3);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mism_3 got rsp=%b exp 0", rsp_valid); end
        arrive(3, 4'd6, 6'd3);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd6) begin errors++;
            $display("FAIL mism_release got rsp=%b id=%0d exp 1 6", rsp_valid, rsp_id); end
        @(posedge clk); #1;
`ifdef VX_GBAR_SCHED_ERR_EN
        checks++; if (err !== 1'b1 || err_id !== 4'd6) begin errors++;
            $display("FAIL err_sticky got err=%b id=%0d exp 1 6", err, err_id); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_immediate();
        test_rr_order();
        test_rr_wrap();
        test_back_to_back();
        test_fresh_gen();
        test_reset_mid();
        test_max_size();
        test_size_mismatch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
